// File: rtl/tester_serial_pkg.sv
// Shared definitions for the tester serial transmit/receive blocks:
// frame state encoding and parity mode codes.
package tester_serial_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/serial_bit_timer.sv
// Reloadable bit-period down-counter: a load strobe latches the period and
// restarts the count; bit_end ticks on the last cycle of every period.
module serial_bit_timer #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  input  logic                 run,
  output logic                 bit_end
);

  logic [DIV_WIDTH-1:0] period_q, period_d;
  logic [DIV_WIDTH-1:0] count_q, count_d;

  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    if (load) begin
      period_d = load_val;
      count_d  = load_val;
    end else if (run) begin
      // Wrap straight to the latched period so consecutive bits abut.
      count_d = (count_q == '0) ? period_q : count_q - DIV_WIDTH'(1);
    end
  end

  assign bit_end = run & ~load & (count_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= '0;
      count_q  <= '0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tester_frame_serializer.sv
// Pops words from the tester shift FIFO and sends each one as an async
// serial frame: start bit, data LSB-first, optional parity, stop bit(s).
module tester_frame_serializer
  import tester_serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 fi_clk,
  input  logic                 fi_rst,
  input  logic                 fi_en,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 fi_stb,
  input  logic [WIDTH-1:0]     fi_dat,
  output logic                 fi_ack,
  output logic                 fo_txd,
  output logic                 fo_busy,
  output logic                 fo_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               par_q, par_d;
  logic               bit_end;

  assign fi_ack = (state_q == S_IDLE) & fi_en & fi_stb & ~fi_rst;

  serial_bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_timer (
    .clk      (fi_clk),
    .rst      (fi_rst),
    .load     (fi_ack),
    .load_val (cfg_div),
    .run      (busy_q),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    par_d   = par_q;
    // The line value for the next bit is chosen one edge early so fo_txd
    // stays a plain flop output.
    case (state_q)
      S_IDLE: begin
        if (fi_ack) begin
          shift_d = fi_dat;
          par_d   = (PARITY == PAR_ODD) ? ~(^fi_dat) : ^fi_dat;
          cnt_d   = '0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          txd_d   = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (cnt_q == LAST_DATA) begin
            cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              txd_d   = par_q;
              state_d = S_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            txd_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (cnt_q == LAST_STOP) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign fo_done = (state_q == S_STOP) & bit_end & (cnt_q == LAST_STOP);
  assign fo_txd  = txd_q;
  assign fo_busy = busy_q;

  always_ff @(posedge fi_clk or posedge fi_rst) begin
    if (fi_rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: tb/tb_tester_frame_serializer.sv
// Directed bench for tester_frame_serializer: a queue stands in for the
// shift FIFO; frames are checked cycle by cycle at the falling edge.
module tb_tester_frame_serializer;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned DIV_WIDTH = 16;

  logic                 fi_clk = 1'b0;
  logic                 fi_rst = 1'b0;
  logic                 fi_en  = 1'b0;
  logic [DIV_WIDTH-1:0] cfg_div = '0;
  logic                 fi_stb = 1'b0;
  logic [WIDTH-1:0]     fi_dat = '0;
  logic                 fi_ack, fo_txd, fo_busy, fo_done;

  logic                 p_en  = 1'b0;
  logic [DIV_WIDTH-1:0] p_div = '0;
  logic                 p_stb = 1'b0;
  logic [WIDTH-1:0]     p_dat = '0;
  logic                 e_ack, e_txd, e_busy, e_done;
  logic                 o_ack, o_txd, o_busy, o_done;

  int checks = 0;
  int errors = 0;
  int ack_count = 0;
  logic [WIDTH-1:0] fifo[$];
  logic pop;

  always #5 fi_clk = ~fi_clk;

  tester_frame_serializer #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH), .PARITY(0), .STOP_BITS(1)) u_dut (
    .fi_clk(fi_clk), .fi_rst(fi_rst), .fi_en(fi_en), .cfg_div(cfg_div), .fi_stb(fi_stb),
    .fi_dat(fi_dat), .fi_ack(fi_ack), .fo_txd(fo_txd), .fo_busy(fo_busy), .fo_done(fo_done));

  tester_frame_serializer #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH), .PARITY(1), .STOP_BITS(1)) u_even (
    .fi_clk(fi_clk), .fi_rst(fi_rst), .fi_en(p_en), .cfg_div(p_div), .fi_stb(p_stb),
    .fi_dat(p_dat), .fi_ack(e_ack), .fo_txd(e_txd), .fo_busy(e_busy), .fo_done(e_done));

  tester_frame_serializer #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH), .PARITY(2), .STOP_BITS(1)) u_odd (
    .fi_clk(fi_clk), .fi_rst(fi_rst), .fi_en(p_en), .cfg_div(p_div), .fi_stb(p_stb),
    .fi_dat(p_dat), .fi_ack(o_ack), .fo_txd(o_txd), .fo_busy(o_busy), .fo_done(o_done));

  // FIFO model: pops on the ack edge, presents the new head shortly after.
  always begin
    @(posedge fi_clk);
    pop = fi_ack;
    #1;
    if (pop && fifo.size() != 0) begin
      void'(fifo.pop_front());
      ack_count++;
    end
    fi_stb = (fifo.size() != 0);
    fi_dat = (fifo.size() != 0) ? fifo[0] : '0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [WIDTH-1:0] w);
    fifo.push_back(w);
    fi_stb = 1'b1;
    fi_dat = fifo[0];
  endtask

  // Expected line level on frame cycle k (1-based from the ack edge).
  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int k, input int p,
                                   input int pm);
    int b;
    b = (k - 1) / p;
    if (b == 0) return 1'b0;
    if (b <= WIDTH) return w[b-1];
    if (pm != 0 && b == WIDTH + 1) return (pm == 1) ? ^w : ~(^w);
    return 1'b1;
  endfunction

  task automatic test_reset();
    fi_rst = 1'b1;
    p_en = 1'b1;
    p_stb = 1'b1;
    #1;
    checks++; if (fo_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", fo_txd); end
    checks++; if (fo_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", fo_busy); end
    checks++; if (fo_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", fo_done); end
    checks++; if (e_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", e_ack); end
    @(negedge fi_clk);
    p_stb = 1'b0;
    p_en = 1'b0;
    fi_rst = 1'b0;
    @(negedge fi_clk);
    checks++; if (fo_txd !== 1'b1 || fo_busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got txd=%b busy=%b want 1 0", fo_txd, fo_busy); end
  endtask

  task automatic test_basic();
    int n;
    int a0;
    logic [15:0] bits;
    a0 = ack_count;
    bits = 16'b1010_0101_1100_0011; // expected LSB-first order read from bit 0 upward
    cfg_div = 16'd3;
    fi_en = 1'b1;
    push(16'hA5C3);
    #1;
    n = 0;
    while (!fi_ack && n < 20) begin @(negedge fi_clk); n++; end
    checks++; if (fi_ack !== 1'b1) begin errors++; $display("FAIL basic_ack_timeout got %b want 1", fi_ack); end
    for (int k = 1; k <= 73; k++) begin
      @(negedge fi_clk);
      if (k <= 4) begin
        checks++; if (fo_txd !== 1'b0) begin errors++; $display("FAIL basic_start k=%0d got %b want 0", k, fo_txd); end
      end else if (k <= 68) begin
        checks++; if (fo_txd !== bits[(k-5)/4]) begin
          errors++; $display("FAIL basic_data k=%0d got %b want %b", k, fo_txd, bits[(k-5)/4]); end
      end else begin
        checks++; if (fo_txd !== 1'b1) begin errors++; $display("FAIL basic_stop k=%0d got %b want 1", k, fo_txd); end
      end
      checks++; if (fo_busy !== (k <= 72)) begin
        errors++; $display("FAIL basic_busy k=%0d got %b want %b", k, fo_busy, (k <= 72)); end
      checks++; if (fo_done !== (k == 72)) begin
        errors++; $display("FAIL basic_done k=%0d got %b want %b", k, fo_done, (k == 72)); end
    end
    checks++; if (ack_count - a0 != 1) begin
      errors++; $display("FAIL basic_ack_count got %0d want 1", ack_count - a0); end
  endtask

  task automatic test_parity();
    int n;
    p_div = 16'd3;
    p_dat = 16'hA5C3;
    p_stb = 1'b1;
    p_en = 1'b1;
    #1;
    n = 0;
    while (!e_ack && n < 20) begin @(negedge fi_clk); n++; end
    checks++; if (e_ack !== 1'b1 || o_ack !== 1'b1) begin
      errors++; $display("FAIL parity_ack got even=%b odd=%b want 1 1", e_ack, o_ack); end
    for (int k = 1; k <= 77; k++) begin
      @(negedge fi_clk);
      if (k == 1) p_stb = 1'b0;
      checks++; if (e_txd !== exp_bit(16'hA5C3, k, 4, 1)) begin
        errors++; $display("FAIL parity_even_txd k=%0d got %b want %b", k, e_txd, exp_bit(16'hA5C3, k, 4, 1)); end
      checks++; if (o_txd !== exp_bit(16'hA5C3, k, 4, 2)) begin
        errors++; $display("FAIL parity_odd_txd k=%0d got %b want %b", k, o_txd, exp_bit(16'hA5C3, k, 4, 2)); end
      if (k == 70) begin
        checks++; if (e_txd !== 1'b0) begin errors++; $display("FAIL parity_even_bit got %b want 0", e_txd); end
        checks++; if (o_txd !== 1'b1) begin errors++; $display("FAIL parity_odd_bit got %b want 1", o_txd); end
      end
      checks++; if (e_done !== (k == 76) || o_done !== (k == 76)) begin
        errors++; $display("FAIL parity_done k=%0d got %b%b want %b", k, e_done, o_done, (k == 76)); end
      checks++; if (o_busy !== (k <= 76)) begin
        errors++; $display("FAIL parity_busy k=%0d got %b want %b", k, o_busy, (k <= 76)); end
    end
    p_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int a0;
    logic [WIDTH-1:0] words [3];
    words[0] = 16'h0001;
    words[1] = 16'h8000;
    words[2] = 16'hBEEF;
    a0 = ack_count;
    cfg_div = 16'd0;
    fi_en = 1'b1;
    for (int i = 0; i < 3; i++) push(words[i]);
    #1;
    n = 0;
    while (!fi_ack && n < 20) begin @(negedge fi_clk); n++; end
    checks++; if (fi_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_timeout got %b want 1", fi_ack); end
    for (int f = 0; f < 3; f++) begin
      for (int k = 1; k <= 18; k++) begin
        @(negedge fi_clk);
        checks++; if (fo_txd !== exp_bit(words[f], k, 1, 0)) begin
          errors++; $display("FAIL b2b_txd f=%0d k=%0d got %b want %b", f, k, fo_txd, exp_bit(words[f], k, 1, 0)); end
        checks++; if (fi_ack !== 1'b0) begin errors++; $display("FAIL b2b_early_ack f=%0d k=%0d got 1 want 0", f, k); end
        checks++; if (fo_done !== (k == 18)) begin
          errors++; $display("FAIL b2b_done f=%0d k=%0d got %b want %b", f, k, fo_done, (k == 18)); end
      end
      @(negedge fi_clk);
      checks++; if (fi_ack !== (f < 2)) begin
        errors++; $display("FAIL b2b_gap_ack f=%0d got %b want %b", f, fi_ack, (f < 2)); end
      checks++; if (fo_busy !== 1'b0 || fo_txd !== 1'b1) begin
        errors++; $display("FAIL b2b_gap_idle f=%0d got busy=%b txd=%b want 0 1", f, fo_busy, fo_txd); end
    end
    checks++; if (ack_count - a0 != 3 || fi_stb !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got acks=%0d stb=%b want 3 0", ack_count - a0, fi_stb); end
  endtask

  task automatic test_flow_control();
    int n;
    fi_en = 1'b1;
    cfg_div = 16'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge fi_clk);
      checks++; if (fi_ack !== 1'b0 || fo_txd !== 1'b1) begin
        errors++; $display("FAIL empty_idle got ack=%b txd=%b want 0 1", fi_ack, fo_txd); end
    end
    push(16'h1357);
    push(16'h2468);
    #1;
    n = 0;
    while (!fi_ack && n < 20) begin @(negedge fi_clk); n++; end
    checks++; if (fi_ack !== 1'b1) begin errors++; $display("FAIL flow_ack_timeout got %b want 1", fi_ack); end
    for (int k = 1; k <= 18; k++) begin
      @(negedge fi_clk);
      if (k == 5) fi_en = 1'b0;
      checks++; if (fo_txd !== exp_bit(16'h1357, k, 1, 0)) begin
        errors++; $display("FAIL flow_txd k=%0d got %b want %b", k, fo_txd, exp_bit(16'h1357, k, 1, 0)); end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge fi_clk);
      checks++; if (fi_ack !== 1'b0 || fo_busy !== 1'b0 || fo_txd !== 1'b1) begin
        errors++; $display("FAIL flow_hold got ack=%b busy=%b txd=%b want 0 0 1", fi_ack, fo_busy, fo_txd); end
    end
    @(negedge fi_clk);
    fi_en = 1'b1;
    #1;
    checks++; if (fi_ack !== 1'b1) begin errors++; $display("FAIL flow_resume_ack got %b want 1", fi_ack); end
    for (int k = 1; k <= 18; k++) begin
      @(negedge fi_clk);
      checks++; if (fo_txd !== exp_bit(16'h2468, k, 1, 0)) begin
        errors++; $display("FAIL flow_resume_txd k=%0d got %b want %b", k, fo_txd, exp_bit(16'h2468, k, 1, 0)); end
    end
    @(negedge fi_clk);
  endtask

  task automatic test_div_change();
    int n;
    fi_en = 1'b1;
    cfg_div = 16'd3;
    push(16'h00FF);
    push(16'hC001);
    #1;
    n = 0;
    while (!fi_ack && n < 20) begin @(negedge fi_clk); n++; end
    checks++; if (fi_ack !== 1'b1) begin errors++; $display("FAIL div_ack_timeout got %b want 1", fi_ack); end
    for (int k = 1; k <= 72; k++) begin
      @(negedge fi_clk);
      if (k == 10) cfg_div = 16'd7;
      checks++; if (fo_txd !== exp_bit(16'h00FF, k, 4, 0)) begin
        errors++; $display("FAIL div_old_txd k=%0d got %b want %b", k, fo_txd, exp_bit(16'h00FF, k, 4, 0)); end
      checks++; if (fo_done !== (k == 72)) begin
        errors++; $display("FAIL div_old_done k=%0d got %b want %b", k, fo_done, (k == 72)); end
    end
    @(negedge fi_clk);
    checks++; if (fi_ack !== 1'b1) begin errors++; $display("FAIL div_next_ack got %b want 1", fi_ack); end
    for (int k = 1; k <= 144; k++) begin
      @(negedge fi_clk);
      checks++; if (fo_txd !== exp_bit(16'hC001, k, 8, 0)) begin
        errors++; $display("FAIL div_new_txd k=%0d got %b want %b", k, fo_txd, exp_bit(16'hC001, k, 8, 0)); end
      checks++; if (fo_done !== (k == 144)) begin
        errors++; $display("FAIL div_new_done k=%0d got %b want %b", k, fo_done, (k == 144)); end
    end
    @(negedge fi_clk);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    fi_en = 1'b1;
    cfg_div = 16'd3;
    push(16'h0000);
    push(16'h5A3C);
    #1;
    n = 0;
    while (!fi_ack && n < 20) begin @(negedge fi_clk); n++; end
    checks++; if (fi_ack !== 1'b1) begin errors++; $display("FAIL rstmid_ack_timeout got %b want 1", fi_ack); end
    for (int k = 1; k <= 30; k++) @(negedge fi_clk);
    checks++; if (fo_txd !== 1'b0 || fo_busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got txd=%b busy=%b want 0 1", fo_txd, fo_busy); end
    fi_rst = 1'b1;
    #1;
    checks++; if (fo_txd !== 1'b1 || fo_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got txd=%b busy=%b want 1 0", fo_txd, fo_busy); end
    checks++; if (fi_ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack got %b want 0", fi_ack); end
    @(negedge fi_clk);
    fi_rst = 1'b0;
    #1;
    checks++; if (fi_ack !== 1'b1) begin errors++; $display("FAIL rstmid_reack got %b want 1", fi_ack); end
    for (int k = 1; k <= 73; k++) begin
      @(negedge fi_clk);
      checks++; if (fo_txd !== exp_bit(16'h5A3C, k, 4, 0)) begin
        errors++; $display("FAIL rstmid_txd k=%0d got %b want %b", k, fo_txd, exp_bit(16'h5A3C, k, 4, 0)); end
      checks++; if (fo_busy !== (k <= 72)) begin
        errors++; $display("FAIL rstmid_busy k=%0d got %b want %b", k, fo_busy, (k <= 72)); end
    end
  endtask

  initial begin
    @(negedge fi_clk);
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_flow_control();
    test_div_change();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
